// File: rtl/uart_tx_ctrl.sv
// Frame sequencer for the UART TX path: start bit, serializer-driven data bits,
// optional parity bit and stop bit. One clk is one bit time.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  par_en_in,
  input  logic                  par_typ_in,
  input  logic                  ser_data_in,
  input  logic                  ser_done_in,
  output logic                  ser_en_out,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  frame_err_out
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic          par_en_q;
  logic          parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      par_en_q      <= 1'b0;
      parity_q      <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid_in) begin
            par_en_q      <= par_en_in;
            parity_q      <= (^data_in) ^ par_typ_in;
            frame_err_out <= 1'b0;
            bit_cnt       <= '0;
            state         <= START;
          end
        end
        START: state <= DATA;
        DATA: begin
          if (ser_done_in) begin
            bit_cnt <= '0;
            state   <= par_en_q ? PARITY : STOP;
          end else if (bit_cnt == LAST_BIT) begin
            // Serializer overran its bit budget: abandon parity, close the frame.
            bit_cnt       <= '0;
            frame_err_out <= 1'b1;
            state         <= STOP;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        PARITY:  state <= STOP;
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore output decode; DATA passes the serializer bit straight to the line.
  always_comb begin
    tx_out     = 1'b1;
    ser_en_out = 1'b0;
    busy_out   = (state != IDLE);
    case (state)
      START:  tx_out = 1'b0;
      DATA: begin
        tx_out     = ser_data_in;
        ser_en_out = 1'b1;
      end
      PARITY: tx_out = parity_q;
      default: tx_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed and random frames for uart_tx_ctrl, checked cycle by cycle against
// a bit-list model of the expected line waveform.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          ser_data;
  logic          ser_done;
  logic          ser_en;
  logic          tx;
  logic          busy;
  logic          frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid_in (data_valid),
    .par_en_in     (par_en),
    .par_typ_in    (par_typ),
    .ser_data_in   (ser_data),
    .ser_done_in   (ser_done),
    .ser_en_out    (ser_en),
    .tx_out        (tx),
    .busy_out      (busy),
    .frame_err_out (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // LSB-first serializer model: loads when the controller is idle, shifts on
  // ser_en, flags done on its DW-th shift cycle unless told to stay silent.
  logic [DW-1:0] sreg;
  int            shifts;
  logic          no_done;

  always @(posedge clk) begin
    if (reset) begin
      sreg   <= '0;
      shifts <= 0;
    end else if (data_valid && !busy) begin
      sreg   <= data_in;
      shifts <= 0;
    end else if (ser_en) begin
      sreg   <= sreg >> 1;
      shifts <= shifts + 1;
    end
  end

  assign ser_data = sreg[0];
  assign ser_done = !no_done && (shifts == DW - 1);

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic ref_parity(input logic [DW-1:0] d, input logic odd);
    return logic'(($countones(d) % 2) != 0) ^ odd;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a clock edge with the controller idle. Sends one frame and
  // checks every bit time plus the following idle cycle.
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic nd, input logic glitch, input logic hold);
    logic exp_q[$];
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pe && !nd) exp_q.push_back(ref_parity(d, pt));
    exp_q.push_back(1'b1);

    no_done    = nd;
    data_in    = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    step();
    if (!hold) data_valid = 1'b0;
    // mid-frame config and data changes must not reach the line
    data_in = DW'($urandom);
    par_en  = 1'($urandom);
    par_typ = 1'($urandom);
    check("frame_err_cleared_at_accept", frame_err, 1'b0);

    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("tx_bit%0d_d%02h", i, d), tx, exp_q[i]);
      check($sformatf("busy_bit%0d", i), busy, 1'b1);
      check($sformatf("ser_en_bit%0d", i), ser_en, (i >= 1 && i <= DW));
      if (glitch && i == 3) begin
        data_valid = 1'b1;
        data_in    = 8'hFF;
      end
      if (glitch && i == 4) data_valid = 1'b0;
      step();
    end
    check("idle_tx", tx, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_ser_en", ser_en, 1'b0);
    check("idle_frame_err", frame_err, nd);
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    no_done    = 1'b0;
    repeat (3) step();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ser_en", ser_en, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    step();

    // plain frame, then parity even/odd
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // request during DATA is ignored, no second frame follows
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      step();
      check("no_extra_frame_busy", busy, 1'b0);
      check("no_extra_frame_tx", tx, 1'b1);
    end

    // reset in the 4th DATA cycle abandons the frame
    data_in    = 8'h96;
    par_en     = 1'b1;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    repeat (4) step();
    check("pre_reset_ser_en", ser_en, 1'b1);
    reset = 1'b1;
    step();
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ser_en", ser_en, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    reset = 1'b0;
    step();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // serializer never signals done: error sticks until the next accept
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("frame_err_sticky", frame_err, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // valid held high: frames separated by exactly one idle cycle
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // random frames with random idle gaps
    for (int k = 0; k < 25; k++) begin
      send_frame(DW'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
